// File: rtl/axi_line_reader_pkg.sv
// axi_line_reader_pkg: FSM states, line geometry and AXI field constants
// shared by the line reader top level and its output register.
package axi_line_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned LINE_BITS  = LINE_BYTES * 8;
    localparam int unsigned LINE_SHIFT = 6;
    localparam int unsigned LINE_AW    = 64 - LINE_SHIFT;

    localparam logic [2:0] ARSIZE_64B = 3'b110;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Byte address of a line number plus a fixed offset, wrapping at 2^64.
    function automatic logic [63:0] line_addr(
        input logic [LINE_AW-1:0] line,
        input logic [63:0]        offset
    );
        return {line, 6'b0} + offset;
    endfunction

endpackage

// File: rtl/axi_if.sv
// axi_if: AXI4 bundle with master and slave views.
// Read and write channels; data width set in bytes.
interface axi_if #(
    parameter int WIDTH_IN_BYTES = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int ID_WIDTH       = 4
);

    logic                        arvalid;
    logic                        arready;
    logic [ADDR_WIDTH-1:0]       araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic [ID_WIDTH-1:0]         arid;

    logic                        rvalid;
    logic                        rready;
    logic [8*WIDTH_IN_BYTES-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic [ID_WIDTH-1:0]         rid;

    logic                        awvalid;
    logic                        awready;
    logic [ADDR_WIDTH-1:0]       awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic [ID_WIDTH-1:0]         awid;

    logic                        wvalid;
    logic                        wready;
    logic [8*WIDTH_IN_BYTES-1:0] wdata;
    logic [WIDTH_IN_BYTES-1:0]   wstrb;
    logic                        wlast;

    logic                        bvalid;
    logic                        bready;
    logic [1:0]                  bresp;
    logic [ID_WIDTH-1:0]         bid;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/axi_line_out_reg.sv
// axi_line_out_reg: one-entry output register for fetched lines.
// A load wins over a same-edge drain and keeps valid set.
module axi_line_out_reg
    import axi_line_reader_pkg::*;
#(
    parameter int unsigned WIDTH = LINE_BITS
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Capture a beat on load, otherwise drop valid once consumed.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axi_line_reader.sv
// axi_line_reader: fetches N 64-byte lines with single-beat AXI reads.
// Define AXI_LINE_READER_RRESP_CHECK_EN to abort and flag on bad rresp.
module axi_line_reader
    import axi_line_reader_pkg::*;
#(
    parameter int          LEN_WIDTH      = 16,
    parameter logic [63:0] ADDRESS_OFFSET = 64'd0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [63:0]          base_addr_i,
    input  logic [LEN_WIDTH-1:0] num_lines_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [LINE_BITS-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    axi_if.master                axi_bus
);

    state_t               state_q;
    state_t               state_d;
    logic [LEN_WIDTH-1:0] index_q;
    logic [LEN_WIDTH-1:0] index_nxt;
    logic [LEN_WIDTH-1:0] num_q;
    logic [LINE_AW-1:0]   line_q;
    logic                 accept;
    logic                 load;
    logic                 arvalid;
    logic                 rready;
    logic                 last_beat;
    logic                 resp_err;

    assign index_nxt = index_q + LEN_WIDTH'(1);
    assign last_beat = (index_nxt == num_q);

`ifdef AXI_LINE_READER_RRESP_CHECK_EN
    logic error_q;

    assign resp_err = (axi_bus.rresp != RESP_OKAY);

    // Sticky error flag, cleared when a new command is accepted.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (load && resp_err) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    assign resp_err = 1'b0;
    assign error_o  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state handshake strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load    = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = (num_lines_i == '0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (axi_bus.arready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rready = ~data_valid_o | data_ready_i;
                if (axi_bus.rvalid && rready) begin
                    load    = 1'b1;
                    state_d = (last_beat || resp_err) ? DONE : ADDR;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch and line index; araddr is derived from these only.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            index_q <= '0;
            num_q   <= '0;
            line_q  <= '0;
        end else if (accept) begin
            index_q <= '0;
            num_q   <= num_lines_i;
            line_q  <= base_addr_i[63:LINE_SHIFT];
        end else if (load) begin
            index_q <= index_nxt;
        end
    end

    assign busy_o = (state_q != IDLE);

    assign axi_bus.arvalid = arvalid;
    assign axi_bus.araddr  = line_addr(line_q + LINE_AW'(index_q), ADDRESS_OFFSET);
    assign axi_bus.arlen   = 8'd0;
    assign axi_bus.arsize  = ARSIZE_64B;
    assign axi_bus.arburst = BURST_INCR;
    assign axi_bus.arid    = '0;
    assign axi_bus.rready  = rready;

    assign axi_bus.awvalid = 1'b0;
    assign axi_bus.awaddr  = '0;
    assign axi_bus.awlen   = 8'd0;
    assign axi_bus.awsize  = ARSIZE_64B;
    assign axi_bus.awburst = BURST_INCR;
    assign axi_bus.awid    = '0;
    assign axi_bus.wvalid  = 1'b0;
    assign axi_bus.wdata   = '0;
    assign axi_bus.wstrb   = '0;
    assign axi_bus.wlast   = 1'b0;
    assign axi_bus.bready  = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{base_addr_i[LINE_SHIFT-1:0], axi_bus.rresp,
                         axi_bus.rlast, axi_bus.rid, axi_bus.awready,
                         axi_bus.wready, axi_bus.bvalid, axi_bus.bresp,
                         axi_bus.bid};

    axi_line_out_reg #(
        .WIDTH (LINE_BITS)
    ) u_out_reg (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .load_i  (load),
        .data_i  (axi_bus.rdata),
        .ready_i (data_ready_i),
        .valid_o (data_valid_o),
        .data_o  (data_o)
    );

endmodule
